// File: rtl/axis_spi_regfile.sv
// SPI command-frame decoder driving NREGS 8-bit control registers, with optional
// AXI4-Stream register readback enabled by defining SPI_REGFILE_READBACK_EN.
//
// state | meaning
// IDLE  | waiting for a command byte
// WDATA | writing data bytes at an auto-incrementing address
// RLEN  | waiting for the readback length byte
// READ  | emitting readback bytes on the m-side
// DROP  | discarding the rest of a malformed frame
module axis_spi_regfile #(
  parameter int NREGS = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic                 s_tlast,
  input  logic [7:0]           s_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic [7:0]           m_tdata,
  output logic [NREGS*8-1:0]   regs_o,
  output logic [7:0]           err_count_o
);

  typedef enum logic [2:0] {IDLE, WDATA, RLEN, READ, DROP} state_t;

`ifdef SPI_REGFILE_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  // Command bits between the write flag and the address field must be zero.
  localparam logic [7:0] RSVD_MASK = 8'h7F & ~8'((1 << AW) - 1);

  state_t        state, state_nxt;
  logic [7:0]    regs [NREGS];
  logic [AW-1:0] addr;
  logic [7:0]    err_cnt;

  logic s_hs, m_hs, rsvd_bad;
  logic cmd_load, wr_en, err_pulse, rd_start, rd_adv;

  assign s_hs     = s_tvalid & s_tready;
  assign m_hs     = m_tvalid & m_tready;
  assign rsvd_bad = |(s_tdata & RSVD_MASK);

`ifdef SPI_REGFILE_READBACK_EN
  assign s_tready = (state != READ);
`else
  assign s_tready = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (s_hs) begin
          if (rsvd_bad)        state_nxt = s_tlast ? IDLE : DROP;
          else if (s_tdata[7]) state_nxt = s_tlast ? IDLE : WDATA;
          else if (s_tlast)    state_nxt = IDLE;
          else                 state_nxt = READBACK ? RLEN : DROP;
        end
      end
      WDATA:   if (s_hs && s_tlast) state_nxt = IDLE;
      RLEN:    if (s_hs) state_nxt = s_tlast ? READ : DROP;
      READ:    if (m_hs && m_tlast) state_nxt = IDLE;
      DROP:    if (s_hs && s_tlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_load  = 1'b0;
    wr_en     = 1'b0;
    err_pulse = 1'b0;
    rd_start  = 1'b0;
    rd_adv    = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_load  = s_hs;
        // Read commands are malformed when they end the frame or readback is absent.
        err_pulse = s_hs & (rsvd_bad | (~s_tdata[7] & (s_tlast | ~READBACK)));
      end
      WDATA: wr_en = s_hs;
      RLEN: begin
        rd_start  = s_hs & s_tlast;
        err_pulse = s_hs & ~s_tlast;
      end
      READ:    rd_adv = m_hs & ~m_tlast;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr    <= '0;
      err_cnt <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (cmd_load)                  addr <= s_tdata[AW-1:0];
      else if (wr_en || rd_start || rd_adv) addr <= addr + AW'(1);
      if (wr_en) regs[addr] <= s_tdata;
      if (err_pulse && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

`ifdef SPI_REGFILE_READBACK_EN
  // rd_cnt counts bytes still owed, including the one held in m_tdata.
  logic [8:0] rd_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tdata  <= '0;
      rd_cnt   <= '0;
    end else if (rd_start) begin
      m_tvalid <= 1'b1;
      m_tdata  <= regs[addr];
      m_tlast  <= (s_tdata == 8'd1);
      rd_cnt   <= (s_tdata == 8'd0) ? 9'd256 : {1'b0, s_tdata};
    end else if (rd_adv) begin
      m_tdata  <= regs[addr];
      m_tlast  <= (rd_cnt == 9'd2);
      rd_cnt   <= rd_cnt - 9'd1;
    end else if (m_hs && m_tlast) begin
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end
  end
`else
  assign m_tvalid = 1'b0;
  assign m_tlast  = 1'b0;
  assign m_tdata  = 8'h00;
`endif

  for (genvar k = 0; k < NREGS; k++) begin : g_regs_o
    assign regs_o[8*k +: 8] = regs[k];
  end

  assign err_count_o = err_cnt;

endmodule

// File: tb/tb_axis_spi_regfile.sv
// Directed self-checking bench for axis_spi_regfile; readback checks follow
// whether SPI_REGFILE_READBACK_EN is defined for the build.
module tb_axis_spi_regfile;

  localparam int NREGS = 16;

  logic               clock = 1'b0;
  logic               reset;
  logic               s_tvalid, s_tready, s_tlast;
  logic [7:0]         s_tdata;
  logic               m_tvalid, m_tready, m_tlast;
  logic [7:0]         m_tdata;
  logic [NREGS*8-1:0] regs_o;
  logic [7:0]         err_count_o;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_regs [NREGS];
  int         exp_err;

  axis_spi_regfile #(.NREGS(NREGS)) dut (
    .clock(clock), .reset(reset),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tdata(m_tdata),
    .regs_o(regs_o), .err_count_o(err_count_o)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, 128'(obs), 128'(exp));
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    chk(tag, 128'(obs), 128'(exp));
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    chk(tag, 128'(obs), 128'(exp));
  endtask

  function automatic logic [127:0] exp_vec();
    logic [127:0] v;
    for (int i = 0; i < NREGS; i++) v[8*i +: 8] = exp_regs[i];
    return v;
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, "_regs"}, regs_o, exp_vec());
    chki({tag, "_err"}, int'(err_count_o), exp_err);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NREGS; i++) exp_regs[i] = 8'h00;
    exp_err = 0;
  endtask

  // Returns #1 after the accepting edge, so registered effects are visible.
  task automatic send_byte(input logic [7:0] d, input logic last);
    int n;
    @(negedge clock);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    n = 0;
    while (!s_tready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk1("s_tready_wait", s_tready, 1'b1);
    @(posedge clock);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  initial begin
    int got, last_cnt, last_pos, cyc;
    reset    = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = 8'h00;
    m_tready = 1'b0;
    clear_model();

    repeat (3) @(posedge clock);
    #1;
    chk1("rst_s_tready_in_reset", s_tready, 1'b1);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk1("rst_m_tvalid", m_tvalid, 1'b0);
    chk1("rst_m_tlast", m_tlast, 1'b0);
    chk8("rst_m_tdata", m_tdata, 8'h00);
    chk1("rst_s_tready", s_tready, 1'b1);
    chk_model("rst");

    send_byte(8'h83, 1'b0);
    send_byte(8'hAA, 1'b0);
    chk8("wr_reg3_after_aa", regs_o[3*8 +: 8], 8'hAA);
    chk8("wr_reg4_before_bb", regs_o[4*8 +: 8], 8'h00);
    send_byte(8'hBB, 1'b1);
    exp_regs[3] = 8'hAA;
    exp_regs[4] = 8'hBB;
    chk_model("wr_basic");

    send_byte(8'h8F, 1'b0);
    send_byte(8'h11, 1'b0);
    chk8("wrap_reg15", regs_o[15*8 +: 8], 8'h11);
    send_byte(8'h22, 1'b1);
    exp_regs[15] = 8'h11;
    exp_regs[0]  = 8'h22;
    chk_model("wr_wrap");

    send_byte(8'h40, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b1);
    exp_err = 1;
    chk_model("rsvd_drop");
    send_byte(8'h85, 1'b0);
    send_byte(8'h77, 1'b1);
    exp_regs[5] = 8'h77;
    chk_model("after_drop");

    send_byte(8'h00, 1'b1);
    exp_err = 2;
    chk_model("read_last_on_cmd");

    send_byte(8'h81, 1'b1);
    chk_model("write_noop");

    send_byte(8'h70, 1'b1);
    exp_err = 3;
    chk_model("rsvd_last_on_cmd");
    send_byte(8'h82, 1'b0);
    send_byte(8'h99, 1'b1);
    exp_regs[2] = 8'h99;
    chk_model("write_after_rsvd");

`ifdef SPI_REGFILE_READBACK_EN
    send_byte(8'h0F, 1'b0);
    send_byte(8'h02, 1'b1);
    chk1("rd2_valid", m_tvalid, 1'b1);
    chk8("rd2_b1_data", m_tdata, 8'h11);
    chk1("rd2_b1_last", m_tlast, 1'b0);
    chk1("rd2_s_tready", s_tready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      chk8("rd2_hold_data", m_tdata, 8'h11);
      chk1("rd2_hold_valid", m_tvalid, 1'b1);
      chk1("rd2_hold_last", m_tlast, 1'b0);
      chk1("rd2_hold_s_tready", s_tready, 1'b0);
    end
    m_tready = 1'b1;
    @(posedge clock);
    #1;
    chk8("rd2_b2_data", m_tdata, 8'h22);
    chk1("rd2_b2_last", m_tlast, 1'b1);
    chk1("rd2_b2_s_tready", s_tready, 1'b0);
    @(posedge clock);
    #1;
    chk1("rd2_done_valid", m_tvalid, 1'b0);
    chk1("rd2_done_s_tready", s_tready, 1'b1);
    chk_model("rd2");

    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b1);
    got = 0;
    last_cnt = 0;
    last_pos = 0;
    cyc = 0;
    while (got < 256 && cyc < 600) begin
      @(negedge clock);
      cyc++;
      if (m_tvalid) begin
        chk8($sformatf("rd256_b%0d", got), m_tdata, exp_regs[got % NREGS]);
        if (m_tlast) begin
          last_cnt++;
          last_pos = got + 1;
        end
        got++;
      end
    end
    @(posedge clock);
    #1;
    chki("rd256_count", got, 256);
    chki("rd256_tlast_count", last_cnt, 1);
    chki("rd256_tlast_pos", last_pos, 256);
    chk1("rd256_done_valid", m_tvalid, 1'b0);
    chk1("rd256_done_s_tready", s_tready, 1'b1);

    send_byte(8'h00, 1'b0);
    send_byte(8'h08, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    chk1("rdrst_valid_before", m_tvalid, 1'b1);
    chk1("rdrst_last_before", m_tlast, 1'b0);
    chk8("rdrst_b4_data", m_tdata, exp_regs[3]);
    reset = 1'b1;
    @(posedge clock);
    #1;
    clear_model();
    chk1("rdrst_valid", m_tvalid, 1'b0);
    chk1("rdrst_last", m_tlast, 1'b0);
    chk8("rdrst_data", m_tdata, 8'h00);
    chk1("rdrst_s_tready", s_tready, 1'b1);
    chk_model("rdrst");
    reset = 1'b0;
    m_tready = 1'b0;
`else
    m_tready = 1'b1;
    send_byte(8'h0F, 1'b0);
    chk1("rdoff_s_tready", s_tready, 1'b1);
    send_byte(8'h02, 1'b1);
    exp_err = 4;
    for (int i = 0; i < 4; i++) begin
      chk1("rdoff_no_valid", m_tvalid, 1'b0);
      chk1("rdoff_no_last", m_tlast, 1'b0);
      chk8("rdoff_data", m_tdata, 8'h00);
      @(posedge clock);
      #1;
    end
    chk_model("rdoff");
    send_byte(8'h8E, 1'b0);
    send_byte(8'h5A, 1'b1);
    exp_regs[14] = 8'h5A;
    chk_model("rdoff_next_frame");
    m_tready = 1'b0;
`endif

    send_byte(8'h83, 1'b0);
    send_byte(8'h44, 1'b0);
    exp_regs[3] = 8'h44;
    chk_model("midwr_before_rst");
    reset = 1'b1;
    @(posedge clock);
    #1;
    clear_model();
    chk_model("midwr_rst");
    chk1("midwr_rst_s_tready", s_tready, 1'b1);
    chk1("midwr_rst_valid", m_tvalid, 1'b0);
    reset = 1'b0;
    send_byte(8'h55, 1'b1);
    exp_err = 1;
    chk_model("midwr_tail_as_cmd");
    send_byte(8'h81, 1'b0);
    send_byte(8'h12, 1'b1);
    exp_regs[1] = 8'h12;
    chk_model("midwr_recover");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
